tri_bus_xfer_ctrl: RTL
======================

// Module: tri_bus_xfer_ctrl
// PURPOSE
// - Single-master transfer sequencer for a shared bidirectional parallel pad bus.
// - Sits directly upstream of the per-pin tri-state IO buffer bank:
//   - pad_o feeds the buffer data input.
//   - pad_oen_n feeds its common active-low output enable.
//   - pad_i is the buffer's pad-to-core output.
// - Converts one-at-a-time core write/read requests into strobe-timed bus cycles.
// - Enforces setup/hold windows and a turnaround gap so the bus is never double-driven.
// PARAMETERS
// - WIDTH     8  bus width in bits (>=1)
// - SETUP_CYC 1  write: cycles data is driven before strobe (>=1)
// - STB_CYC   2  strobe high cycles, read and write (>=1)
// - HOLD_CYC  1  write: cycles data is held after strobe falls (>=1)
// - TURN_CYC  2  bus-released cycles after every transfer before the next accept (>=1)
// PORTS
// - clk        in   1      single clock; all logic on rising edge
// - rst        in   1      synchronous, active-high reset
// - req_valid  in   1      transfer request
// - req_ready  out  1      high only in IDLE; accept = req_valid & req_ready
// - req_wr     in   1      1=write, 0=read; sampled at accept
// - req_wdata  in   WIDTH  write data; sampled at accept
// - rsp_valid  out  1      one-cycle pulse; read data valid; no backpressure
// - rsp_rdata  out  WIDTH  read data; holds until next read completes
// - pad_o      out  WIDTH  data toward pads (to buffer din)
// - pad_oen_n  out  1      0=drive pads, 1=tristate/input (to buffer oen_N)
// - pad_i      in   WIDTH  data from pads (from buffer dout)
// - pad_stb    out  1      active-high transfer strobe
// - pad_rnw    out  1      1=read cycle, 0=write cycle
// BEHAVIOUR
// - All outputs registered. Reset values:
//   - pad_oen_n=1, pad_stb=0, pad_rnw=1, pad_o=0
//   - req_ready=0 while rst is high, 1 in the cycle after rst deasserts
//   - rsp_valid=0, rsp_rdata=0
// - FSM states: IDLE, WR_SETUP, WR_STB, WR_HOLD, RD_STB, [RD_SYNC], TURN.
//   - One down-counter, width $clog2(max param)+1, is loaded on every state entry.
// - Write accepted at edge t:
//   - WR_SETUP SETUP_CYC cycles (oen_n=0, pad_o=wdata, rnw=0, stb=0)
//   - -> WR_STB STB_CYC cycles (stb=1)
//   - -> WR_HOLD HOLD_CYC cycles (stb=0, still driving)
//   - -> TURN.
// - Read accepted at edge t:
//   - RD_STB STB_CYC cycles (oen_n=1, rnw=1, stb=1).
//   - pad_i is captured at the edge ending the last STB cycle.
//   - rsp_valid is high in the following cycle, which is also the first TURN cycle.
// - TURN: oen_n=1, stb=0, rnw=1, pad_o=0 for TURN_CYC cycles, then IDLE (req_ready=1).
// - Accept-to-ready latency:
//   - write: 1+SETUP+STB+HOLD+TURN
//   - read:  1+STB+TURN
// - pad_oen_n is 0 only in WR_SETUP/WR_STB/WR_HOLD; it always rises before TURN begins.
// - req_valid low in IDLE: stay IDLE, outputs at reset levels. No pipelining: one transfer in flight.
// - req_wr/req_wdata changes after accept are ignored (data latched at accept).
// - rst mid-transfer: next edge forces IDLE-reset values.
//   - Bus released, strobe dropped, no rsp_valid; in-flight read is lost.
// CONFIGURATION
// - TRI_BUS_XFER_IN_SYNC_EN defined:
//   - pad_i passes through a 2-flop synchronizer (flops reset to 0).
//   - RD_STB is followed by RD_SYNC for 2 cycles, with stb=0 and bus released.
//   - Capture happens at the end of RD_SYNC; read latency becomes 1+STB+2+TURN.
// - Undefined: no synchronizer, no RD_SYNC state; pad_i is sampled directly as described above.
// TESTING
// - Reset release, defaults:
//   - pad_oen_n=1, stb=0, rnw=1, req_ready=0 during rst.
//   - req_ready=1 on the first cycle after rst falls.
// - Write 0xA5:
//   - oen_n=0 for exactly 4 cycles, pad_o=0xA5 throughout.
//   - stb high exactly cycles 2-3 after accept.
//   - req_ready returns 7 cycles after accept.
// - Read, pad_i=0x3C during strobe (changed to 0xFF afterwards):
//   - oen_n stays 1.
//   - rsp_valid single pulse 3 cycles after accept, rsp_rdata=0x3C.
//   - ready returns 5 cycles after accept.
// - Back-to-back write then read with req_valid held high:
//   - the read accept occurs only after the TURN cycles.
//   - at no cycle are oen_n=0 and rnw=1 both true.
// - rst asserted during WR_STB:
//   - next cycle oen_n=1, stb=0.
//   - no rsp_valid.
//   - the following transfer completes normally.
// - With TRI_BUS_XFER_IN_SYNC_EN, read 0x5A:
//   - rsp_valid 5 cycles after accept with rdata=0x5A.
//   - ready returns 7 cycles after accept.

Source files
------------

// File: rtl/tri_bus_xfer_ctrl_if.sv
// Core-request and pad-bus signal bundle for tri_bus_xfer_ctrl.
// master = the transfer sequencer, slave = core + IO buffer bank side.
interface tri_bus_xfer_ctrl_if #(
  parameter int WIDTH = 8
);
  // Handshake: a request is accepted on the rising edge where req_valid and
  // req_ready are both high; req_wr/req_wdata are sampled only at that edge.
  // rsp_valid is a one-cycle pulse with no backpressure.
  logic             req_valid;
  logic             req_ready;
  logic             req_wr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic [WIDTH-1:0] pad_o;
  logic             pad_oen_n;
  logic [WIDTH-1:0] pad_i;
  logic             pad_stb;
  logic             pad_rnw;

  modport master (
    input  req_valid, req_wr, req_wdata, pad_i,
    output req_ready, rsp_valid, rsp_rdata, pad_o, pad_oen_n, pad_stb, pad_rnw
  );

  modport slave (
    output req_valid, req_wr, req_wdata, pad_i,
    input  req_ready, rsp_valid, rsp_rdata, pad_o, pad_oen_n, pad_stb, pad_rnw
  );
endinterface

// File: rtl/tri_bus_xfer_ctrl.sv
// Strobe-timed write/read sequencer for a shared tri-state pad bus.
// Optional pad_i 2-flop synchronizer + RD_SYNC state via TRI_BUS_XFER_IN_SYNC_EN.
module tri_bus_xfer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int STB_CYC   = 2,
  parameter int HOLD_CYC  = 1,
  parameter int TURN_CYC  = 2
) (
  input  logic                clk,
  input  logic                rst,
  tri_bus_xfer_ctrl_if.master bus,
  output logic [2:0]          o_dbg_state
);

  localparam int M_A  = (SETUP_CYC > STB_CYC) ? SETUP_CYC : STB_CYC;
  localparam int M_B  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int M_C  = (M_A > M_B) ? M_A : M_B;
  localparam int MAXP = (M_C > 2) ? M_C : 2;
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_STB   = CW'(STB_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_TURN  = CW'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_STB   = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD_STB   = 3'd4,
    S_TURN     = 3'd5
`ifdef TRI_BUS_XFER_IN_SYNC_EN
    ,S_RD_SYNC = 3'd6
`endif
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_pad_o;
  logic             r_oen_n;
  logic             r_stb;
  logic             r_rnw;
  logic             w_cnt_done;

  assign w_cnt_done = (r_cnt == '0);

`ifdef TRI_BUS_XFER_IN_SYNC_EN
  localparam logic [CW-1:0] LD_SYNC = CW'(1);
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.pad_i;
      r_sync2 <= r_sync1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_pad_o     <= '0;
      r_oen_n     <= 1'b1;
      r_stb       <= 1'b0;
      r_rnw       <= 1'b1;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_ready && bus.req_valid) begin
            r_ready <= 1'b0;
            if (bus.req_wr) begin
              r_state <= S_WR_SETUP;
              r_cnt   <= LD_SETUP;
              r_oen_n <= 1'b0;
              r_pad_o <= bus.req_wdata;
              r_rnw   <= 1'b0;
            end else begin
              r_state <= S_RD_STB;
              r_cnt   <= LD_STB;
              r_stb   <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_WR_SETUP: begin
          if (w_cnt_done) begin
            r_state <= S_WR_STB;
            r_cnt   <= LD_STB;
            r_stb   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WR_STB: begin
          if (w_cnt_done) begin
            r_state <= S_WR_HOLD;
            r_cnt   <= LD_HOLD;
            r_stb   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        // Release the bus on leaving HOLD so TURN always starts undriven.
        S_WR_HOLD: begin
          if (w_cnt_done) begin
            r_state <= S_TURN;
            r_cnt   <= LD_TURN;
            r_oen_n <= 1'b1;
            r_rnw   <= 1'b1;
            r_pad_o <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RD_STB: begin
          if (w_cnt_done) begin
            r_stb <= 1'b0;
`ifdef TRI_BUS_XFER_IN_SYNC_EN
            r_state <= S_RD_SYNC;
            r_cnt   <= LD_SYNC;
`else
            r_state     <= S_TURN;
            r_cnt       <= LD_TURN;
            r_rdata     <= bus.pad_i;
            r_rsp_valid <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`ifdef TRI_BUS_XFER_IN_SYNC_EN
        // Two cycles let the strobe-end sample reach the synchronizer output.
        S_RD_SYNC: begin
          if (w_cnt_done) begin
            r_state     <= S_TURN;
            r_cnt       <= LD_TURN;
            r_rdata     <= r_sync2;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
`endif
        S_TURN: begin
          if (w_cnt_done) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_pad_o <= '0;
          r_oen_n <= 1'b1;
          r_stb   <= 1'b0;
          r_rnw   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.pad_o     = r_pad_o;
  assign bus.pad_oen_n = r_oen_n;
  assign bus.pad_stb   = r_stb;
  assign bus.pad_rnw   = r_rnw;
  assign o_dbg_state   = r_state;

endmodule
